// File: rtl/accumulator_unit_if.sv
// ============================================================================
// Module  : accumulator_unit_if
// Command/operand inputs and display/status outputs of the accumulator unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface accumulator_unit_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 8
);
    logic              enterCmd;
    logic              numberCmd;
    logic              totalCmd;
    logic              clearCmd;
    logic              errCmd;
    logic [DATA_W-1:0] numIn;
    logic [ACC_W-1:0]  display;
    logic              showTotal;
    logic              ovf;
    logic              errFlag;
    logic [CNT_W-1:0]  entryCount;
    logic [1:0]        state;

    modport master (
        output enterCmd, numberCmd, totalCmd, clearCmd, errCmd, numIn,
        input  display, showTotal, ovf, errFlag, entryCount, state
    );

    modport slave (
        input  enterCmd, numberCmd, totalCmd, clearCmd, errCmd, numIn,
        output display, showTotal, ovf, errFlag, entryCount, state
    );
endinterface

`default_nettype wire

// File: rtl/accumulator_unit.sv
// ============================================================================
// Module  : accumulator_unit
// Adding-machine datapath: latches operands, accumulates, shows total, flags errors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module accumulator_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    accumulator_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OPERAND = 2'd1,
        S_TOTAL   = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_operand;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_display;
    logic               r_show_total;
    logic               r_ovf;
    logic               r_err_flag;
    logic [CNT_W-1:0]   r_entry_count;
    logic               r_prev_enter;
    logic               r_prev_number;
    logic               r_prev_total;
    logic               r_prev_clear;

    logic               w_enter_edge;
    logic               w_number_edge;
    logic               w_total_edge;
    logic               w_clear_edge;
    logic [ACC_W:0]     w_sum;

    assign w_enter_edge  = bus.enterCmd  & ~r_prev_enter;
    assign w_number_edge = bus.numberCmd & ~r_prev_number;
    assign w_total_edge  = bus.totalCmd  & ~r_prev_total;
    assign w_clear_edge  = bus.clearCmd  & ~r_prev_clear;

    // One extra bit so a carry out of the accumulator is visible as overflow.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W+1-DATA_W){1'b0}}, r_operand};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_operand     <= '0;
            r_acc         <= '0;
            r_display     <= '0;
            r_show_total  <= 1'b0;
            r_ovf         <= 1'b0;
            r_err_flag    <= 1'b0;
            r_entry_count <= '0;
            r_prev_enter  <= 1'b0;
            r_prev_number <= 1'b0;
            r_prev_total  <= 1'b0;
            r_prev_clear  <= 1'b0;
        end else begin
            r_prev_enter  <= bus.enterCmd;
            r_prev_number <= bus.numberCmd;
            r_prev_total  <= bus.totalCmd;
            r_prev_clear  <= bus.clearCmd;

            if (bus.errCmd) begin
                r_state    <= S_ERROR;
                r_err_flag <= 1'b1;
            end else if (w_clear_edge) begin
                r_state       <= S_IDLE;
                r_operand     <= '0;
                r_acc         <= '0;
                r_display     <= '0;
                r_show_total  <= 1'b0;
                r_ovf         <= 1'b0;
                r_err_flag    <= 1'b0;
                r_entry_count <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_TOTAL: begin
                        if (w_number_edge) begin
                            r_operand    <= bus.numIn;
                            r_display    <= {{(ACC_W-DATA_W){1'b0}}, bus.numIn};
                            r_show_total <= 1'b0;
                            r_state      <= S_OPERAND;
                        end else if (w_total_edge && r_state == S_IDLE) begin
                            r_display    <= r_acc;
                            r_show_total <= 1'b1;
                            r_state      <= S_TOTAL;
                        end
                    end
                    S_OPERAND: begin
                        if (w_number_edge) begin
                            r_operand    <= bus.numIn;
                            r_display    <= {{(ACC_W-DATA_W){1'b0}}, bus.numIn};
                            r_show_total <= 1'b0;
                        end else if (w_total_edge) begin
                            r_display    <= r_acc;
                            r_show_total <= 1'b1;
                            r_state      <= S_TOTAL;
                        end else if (w_enter_edge) begin
                            if (!w_sum[ACC_W]) begin
                                r_acc        <= w_sum[ACC_W-1:0];
                                r_display    <= w_sum[ACC_W-1:0];
                                r_show_total <= 1'b0;
                                r_state      <= S_IDLE;
                                if (r_entry_count != {CNT_W{1'b1}}) begin
                                    r_entry_count <= r_entry_count + 1'b1;
                                end
                            end else begin
                                r_ovf      <= 1'b1;
                                r_err_flag <= 1'b1;
                                r_state    <= S_ERROR;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_ERROR;
                    end
                endcase
            end
        end
    end

    assign bus.display    = r_display;
    assign bus.showTotal  = r_show_total;
    assign bus.ovf        = r_ovf;
    assign bus.errFlag    = r_err_flag;
    assign bus.entryCount = r_entry_count;
    assign bus.state      = r_state;
endmodule

`default_nettype wire

// File: tb/tb_accumulator_unit.sv
// ============================================================================
// Module  : tb_accumulator_unit
// Directed self-checking bench for accumulator_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_accumulator_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    accumulator_unit_if #(.DATA_W(8), .ACC_W(12), .CNT_W(8)) bus ();

    accumulator_unit #(.DATA_W(8), .ACC_W(12), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        bus.enterCmd  = 1'b0;
        bus.numberCmd = 1'b0;
        bus.totalCmd  = 1'b0;
        bus.clearCmd  = 1'b0;
        bus.errCmd    = 1'b0;
        bus.numIn     = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // key: 0 number, 1 enter, 2 total, 3 clear, 4 err; held for one cycle
    task automatic press(input int key, input logic [7:0] val);
        @(negedge clk);
        bus.numIn = val;
        case (key)
            0: bus.numberCmd = 1'b1;
            1: bus.enterCmd  = 1'b1;
            2: bus.totalCmd  = 1'b1;
            3: bus.clearCmd  = 1'b1;
            default: bus.errCmd = 1'b1;
        endcase
        @(negedge clk);
        bus.numberCmd = 1'b0;
        bus.enterCmd  = 1'b0;
        bus.totalCmd  = 1'b0;
        bus.clearCmd  = 1'b0;
        bus.errCmd    = 1'b0;
    endtask

    task automatic add(input logic [7:0] val);
        press(0, val);
        press(1, 8'd0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.display !== 12'd0 || bus.showTotal !== 1'b0 || bus.ovf !== 1'b0 ||
            bus.errFlag !== 1'b0 || bus.entryCount !== 8'd0 || bus.state !== 2'd0) begin
            failures++;
            $display("FAIL reset: display=%0d showTotal=%b ovf=%b errFlag=%b count=%0d state=%0d, required all 0",
                     bus.display, bus.showTotal, bus.ovf, bus.errFlag, bus.entryCount, bus.state);
        end
    endtask

    task automatic test_single_add();
        apply_reset();
        press(0, 8'd5);
        checks++;
        if (bus.display !== 12'd5 || bus.state !== 2'd1) begin
            failures++;
            $display("FAIL operand_load: display=%0d state=%0d, required 5/1", bus.display, bus.state);
        end
        press(1, 8'd0);
        checks++;
        if (bus.display !== 12'd5 || bus.entryCount !== 8'd1 || bus.state !== 2'd0 || bus.showTotal !== 1'b0) begin
            failures++;
            $display("FAIL single_add: display=%0d count=%0d state=%0d showTotal=%b, required 5/1/0/0",
                     bus.display, bus.entryCount, bus.state, bus.showTotal);
        end
        press(2, 8'd0);
        checks++;
        if (bus.display !== 12'd5 || bus.showTotal !== 1'b1 || bus.state !== 2'd2) begin
            failures++;
            $display("FAIL single_total: display=%0d showTotal=%b state=%0d, required 5/1/2",
                     bus.display, bus.showTotal, bus.state);
        end
    endtask

    task automatic test_total();
        apply_reset();
        add(8'd200);
        add(8'd100);
        press(2, 8'd0);
        checks++;
        if (bus.display !== 12'd300 || bus.showTotal !== 1'b1 || bus.state !== 2'd2 || bus.entryCount !== 8'd2) begin
            failures++;
            $display("FAIL total_300: display=%0d showTotal=%b state=%0d count=%0d, required 300/1/2/2",
                     bus.display, bus.showTotal, bus.state, bus.entryCount);
        end
        press(1, 8'd0);
        press(2, 8'd0);
        checks++;
        if (bus.display !== 12'd300 || bus.showTotal !== 1'b1 || bus.state !== 2'd2) begin
            failures++;
            $display("FAIL total_ignore: display=%0d showTotal=%b state=%0d, required 300/1/2",
                     bus.display, bus.showTotal, bus.state);
        end
        press(0, 8'd9);
        checks++;
        if (bus.display !== 12'd9 || bus.showTotal !== 1'b0 || bus.state !== 2'd1) begin
            failures++;
            $display("FAIL total_to_operand: display=%0d showTotal=%b state=%0d, required 9/0/1",
                     bus.display, bus.showTotal, bus.state);
        end
        press(1, 8'd0);
        checks++;
        if (bus.display !== 12'd309 || bus.entryCount !== 8'd3) begin
            failures++;
            $display("FAIL acc_kept: display=%0d count=%0d, required 309/3", bus.display, bus.entryCount);
        end
    endtask

    task automatic test_held_enter();
        apply_reset();
        press(0, 8'd7);
        @(negedge clk);
        bus.enterCmd = 1'b1;
        repeat (10) @(negedge clk);
        bus.enterCmd = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.display !== 12'd7 || bus.entryCount !== 8'd1 || bus.state !== 2'd0) begin
            failures++;
            $display("FAIL held_enter: display=%0d count=%0d state=%0d, required 7/1/0",
                     bus.display, bus.entryCount, bus.state);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 16; i++) add(8'd255);
        add(8'd10);
        checks++;
        if (bus.display !== 12'd4090 || bus.entryCount !== 8'd17) begin
            failures++;
            $display("FAIL acc_4090: display=%0d count=%0d, required 4090/17", bus.display, bus.entryCount);
        end
        add(8'd10);
        checks++;
        if (bus.ovf !== 1'b1 || bus.errFlag !== 1'b1 || bus.state !== 2'd3 ||
            bus.display !== 12'd10 || bus.entryCount !== 8'd17) begin
            failures++;
            $display("FAIL overflow: ovf=%b errFlag=%b state=%0d display=%0d count=%0d, required 1/1/3/10/17",
                     bus.ovf, bus.errFlag, bus.state, bus.display, bus.entryCount);
        end
        add(8'd3);
        press(2, 8'd0);
        checks++;
        if (bus.state !== 2'd3 || bus.display !== 12'd10 || bus.showTotal !== 1'b0 || bus.ovf !== 1'b1) begin
            failures++;
            $display("FAIL error_frozen: state=%0d display=%0d showTotal=%b ovf=%b, required 3/10/0/1",
                     bus.state, bus.display, bus.showTotal, bus.ovf);
        end
        press(3, 8'd0);
        checks++;
        if (bus.display !== 12'd0 || bus.ovf !== 1'b0 || bus.errFlag !== 1'b0 ||
            bus.entryCount !== 8'd0 || bus.state !== 2'd0) begin
            failures++;
            $display("FAIL ovf_clear: display=%0d ovf=%b errFlag=%b count=%0d state=%0d, required all 0",
                     bus.display, bus.ovf, bus.errFlag, bus.entryCount, bus.state);
        end
        press(2, 8'd0);
        checks++;
        if (bus.display !== 12'd0 || bus.showTotal !== 1'b1) begin
            failures++;
            $display("FAIL acc_cleared: display=%0d showTotal=%b, required 0/1", bus.display, bus.showTotal);
        end
    endtask

    task automatic test_err_cmd();
        apply_reset();
        press(0, 8'd4);
        press(4, 8'd0);
        checks++;
        if (bus.state !== 2'd3 || bus.errFlag !== 1'b1 || bus.ovf !== 1'b0 || bus.display !== 12'd4) begin
            failures++;
            $display("FAIL err_cmd: state=%0d errFlag=%b ovf=%b display=%0d, required 3/1/0/4",
                     bus.state, bus.errFlag, bus.ovf, bus.display);
        end
        press(3, 8'd0);
        checks++;
        if (bus.state !== 2'd0 || bus.errFlag !== 1'b0 || bus.ovf !== 1'b0 || bus.display !== 12'd0) begin
            failures++;
            $display("FAIL err_clear: state=%0d errFlag=%b ovf=%b display=%0d, required 0/0/0/0",
                     bus.state, bus.errFlag, bus.ovf, bus.display);
        end
        // err level outranks a simultaneous clear edge
        @(negedge clk);
        bus.errCmd   = 1'b1;
        bus.clearCmd = 1'b1;
        @(negedge clk);
        bus.errCmd   = 1'b0;
        bus.clearCmd = 1'b0;
        checks++;
        if (bus.state !== 2'd3 || bus.errFlag !== 1'b1) begin
            failures++;
            $display("FAIL err_priority: state=%0d errFlag=%b, required 3/1", bus.state, bus.errFlag);
        end
    endtask

    task automatic test_count_saturate();
        apply_reset();
        for (int i = 0; i < 256; i++) add(8'd0);
        checks++;
        if (bus.entryCount !== 8'd255 || bus.state !== 2'd0) begin
            failures++;
            $display("FAIL count_saturate: count=%0d state=%0d, required 255/0", bus.entryCount, bus.state);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk);
        bus.numIn     = 8'd5;
        bus.numberCmd = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.display !== 12'd5 || bus.state !== 2'd1) begin
            failures++;
            $display("FAIL pre_reset: display=%0d state=%0d, required 5/1", bus.display, bus.state);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.display !== 12'd0 || bus.state !== 2'd0 || bus.entryCount !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: display=%0d state=%0d count=%0d, required 0/0/0",
                     bus.display, bus.state, bus.entryCount);
        end
        @(negedge clk);
        bus.numberCmd = 1'b0;
        rst_n = 1'b1;
        press(1, 8'd0);
        checks++;
        if (bus.display !== 12'd0 || bus.entryCount !== 8'd0 || bus.state !== 2'd0) begin
            failures++;
            $display("FAIL no_add_after_reset: display=%0d count=%0d state=%0d, required 0/0/0",
                     bus.display, bus.entryCount, bus.state);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        test_reset();
        test_single_add();
        test_total();
        test_held_enter();
        test_overflow();
        test_err_cmd();
        test_count_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
